// File: rtl/mips_loader_pkg.sv
// Shared types and defaults for the MIPS instruction loader.
package mips_loader_pkg;

    localparam int DEFAULT_WIDTH    = 32;
    localparam int DEFAULT_DEPTH    = 4;
    localparam int DEFAULT_CHANNELS = 2;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        RUN   = 2'd3
    } loader_state_t;

endpackage

// File: rtl/mips_loader_if.sv
// Host load handshake, instruction-memory write bus and data-memory probe bus.
interface mips_loader_if
    import mips_loader_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int CHANNELS = DEFAULT_CHANNELS
);
    logic                           load_valid_in;
    logic                           load_ready_out;
    logic [WIDTH-1:0]               load_address_in;
    logic [WIDTH-1:0]               load_instr_in;
    logic                           instrWrite_out;
    logic [WIDTH-1:0]               instr_address_out;
    logic [WIDTH-1:0]               instr_out;
    logic [CHANNELS-1:0]            probe_req_in;
    logic [CHANNELS-1:0][WIDTH-1:0] probe_address_in;
    logic [CHANNELS-1:0]            probe_ack_out;
    logic [CHANNELS-1:0][WIDTH-1:0] probe_data_out;
    logic [WIDTH-1:0]               read_data_address_out;
    logic [WIDTH-1:0]               read_data_in;

    modport slave (
        input  load_valid_in, load_address_in, load_instr_in,
        input  probe_req_in, probe_address_in, read_data_in,
        output load_ready_out, instrWrite_out, instr_address_out, instr_out,
        output probe_ack_out, probe_data_out, read_data_address_out
    );

    modport master (
        output load_valid_in, load_address_in, load_instr_in,
        output probe_req_in, probe_address_in, read_data_in,
        input  load_ready_out, instrWrite_out, instr_address_out, instr_out,
        input  probe_ack_out, probe_data_out, read_data_address_out
    );

endinterface

// File: rtl/mips_loader_fifo.sv
// Load-word FIFO: {address, instruction} entries, pointers carry a wrap bit.
module loader_fifo
    import mips_loader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_addr,
    input  logic [WIDTH-1:0] i_instr,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_addr,
    output logic [WIDTH-1:0] o_instr,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]        r_wptr, r_rptr;
    logic [2*WIDTH-1:0] r_mem [DEPTH];
    logic               w_push, w_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign {o_addr, o_instr} = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: emptiness is defined by the pointers alone.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= {i_addr, i_instr};
    end

endmodule

// File: rtl/mips_loader.sv
// Instruction loader with core-reset FSM and round-robin data-memory probes.
// Optional checksum_out output enabled by defining MIPS_LOADER_CHECKSUM_EN.
module mips_loader
    import mips_loader_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int CHANNELS = DEFAULT_CHANNELS
) (
    input  logic             clock,
    input  logic             reset_in,
    input  logic             start_in,
    input  logic             halt_in,
    output logic             cpu_reset_out,
    output logic [WIDTH-1:0] load_count_out,
`ifdef MIPS_LOADER_CHECKSUM_EN
    output logic [WIDTH-1:0] checksum_out,
`endif
    mips_loader_if.slave     bus
);
    localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    loader_state_t r_state, w_state_next;
    logic             w_push, w_pop, w_full, w_empty, w_start, w_clear;
    logic [WIDTH-1:0] w_head_addr, w_head_instr;
    logic             r_write, r_cpu_reset;
    logic [WIDTH-1:0] r_waddr, r_wdata, r_count;

    assign bus.load_ready_out = !w_full && (r_state != RUN);
    assign w_push  = bus.load_valid_in && bus.load_ready_out;
    assign w_pop   = !w_empty;
    assign w_start = start_in && !halt_in;
    assign w_clear = (r_state == RUN) && halt_in;

    loader_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (clock),
        .i_rst_n (reset_in),
        .i_push  (w_push),
        .i_addr  (bus.load_address_in),
        .i_instr (bus.load_instr_in),
        .i_pop   (w_pop),
        .o_addr  (w_head_addr),
        .o_instr (w_head_instr),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A word pushed on the start edge counts as queued, so it is never stranded in RUN.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            HOLD:    if (w_start && w_empty && !w_push) w_state_next = RUN;
                     else if (w_push)                   w_state_next = LOAD;
            LOAD:    if (w_start) w_state_next = (w_empty && !w_push) ? RUN : DRAIN;
            DRAIN:   if (w_empty && !w_push && !r_write) w_state_next = RUN;
            RUN:     if (halt_in) w_state_next = HOLD;
            default: w_state_next = HOLD;
        endcase
    end

    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in) begin
            r_state     <= HOLD;
            r_cpu_reset <= 1'b1;
            r_write     <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cpu_reset <= (w_state_next != RUN);
            r_write     <= w_pop;
            if (w_pop) begin
                r_waddr <= w_head_addr;
                r_wdata <= w_head_instr;
            end
            if (w_clear)    r_count <= '0;
            else if (w_pop) r_count <= r_count + WIDTH'(1);
        end
    end

    assign cpu_reset_out         = r_cpu_reset;
    assign bus.instrWrite_out    = r_write;
    assign bus.instr_address_out = r_waddr;
    assign bus.instr_out         = r_wdata;
    assign load_count_out        = r_count;

`ifdef MIPS_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] r_csum;

    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in)  r_csum <= '0;
        else if (w_clear) r_csum <= '0;
        else if (w_pop)   r_csum <= r_csum ^ w_head_instr;
    end

    assign checksum_out = r_csum;
`endif

    logic [CHANNELS-1:0]            w_elig, r_ack;
    logic [CHANNELS-1:0][WIDTH-1:0] r_pdata;
    logic [PTR_W-1:0]               r_rr, w_gnt, w_hi, w_lo;
    logic                           w_gnt_vld, w_hi_vld, w_lo_vld;

    // Channels in their ack cycle are masked so a held request is not served twice.
    assign w_elig = bus.probe_req_in & ~r_ack;

    always_comb begin
        w_hi_vld = 1'b0;
        w_lo_vld = 1'b0;
        w_hi     = '0;
        w_lo     = '0;
        for (int j = CHANNELS - 1; j >= 0; j--) begin
            if (w_elig[j]) begin
                if (j >= int'(r_rr)) begin
                    w_hi_vld = 1'b1;
                    w_hi     = PTR_W'(j);
                end
                w_lo_vld = 1'b1;
                w_lo     = PTR_W'(j);
            end
        end
        w_gnt_vld = w_hi_vld || w_lo_vld;
        w_gnt     = w_hi_vld ? w_hi : w_lo;
    end

    assign bus.read_data_address_out = w_gnt_vld ? bus.probe_address_in[w_gnt] : '0;

    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in) begin
            r_rr    <= '0;
            r_ack   <= '0;
            r_pdata <= '0;
        end else begin
            r_ack <= '0;
            if (w_gnt_vld) begin
                r_ack[w_gnt]   <= 1'b1;
                r_pdata[w_gnt] <= bus.read_data_in;
                r_rr           <= (int'(w_gnt) == CHANNELS - 1) ? '0 : w_gnt + PTR_W'(1);
            end
        end
    end

    assign bus.probe_ack_out  = r_ack;
    assign bus.probe_data_out = r_pdata;

endmodule

// File: tb/tb_mips_loader.sv
// Directed bench for mips_loader: loading, drain, halt, probes, reset abort.
module tb_mips_loader;
    localparam int W = 32;

    logic clock, reset_in, start_in, halt_in, cpu_reset_out;
    logic [W-1:0] load_count_out;
`ifdef MIPS_LOADER_CHECKSUM_EN
    logic [W-1:0] checksum_out;
`endif

    mips_loader_if #(.WIDTH(W), .CHANNELS(2)) bus ();

    mips_loader #(.WIDTH(W), .DEPTH(4), .CHANNELS(2)) dut (
        .clock          (clock),
        .reset_in       (reset_in),
        .start_in       (start_in),
        .halt_in        (halt_in),
        .cpu_reset_out  (cpu_reset_out),
        .load_count_out (load_count_out),
`ifdef MIPS_LOADER_CHECKSUM_EN
        .checksum_out   (checksum_out),
`endif
        .bus            (bus)
    );

    function automatic logic [W-1:0] mem_model(input logic [W-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign bus.read_data_in = mem_model(bus.read_data_address_out);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct { logic [W-1:0] addr; logic [W-1:0] data; logic [W-1:0] count; } wr_rec_t;
    typedef struct { logic [W-1:0] addr; logic [W-1:0] instr; logic [W-1:0] exp_count; } load_vec_t;
    typedef struct { int ch; logic [W-1:0] addr; logic [1:0] exp_ack; } probe_vec_t;

    wr_rec_t wr_q[$];

    always @(negedge clock) begin
        if (bus.instrWrite_out)
            wr_q.push_back('{bus.instr_address_out, bus.instr_out, load_count_out});
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    load_vec_t  lv[6];
    probe_vec_t pv[3];
    int         n0;

    initial begin
        lv[0] = '{32'h0000_0100, 32'h8C01_0000, 32'd1};
        lv[1] = '{32'h0000_0104, 32'h8C02_0004, 32'd2};
        lv[2] = '{32'h0000_0108, 32'h0022_1820, 32'd3};
        lv[3] = '{32'h0000_010C, 32'hAC03_0008, 32'd4};
        lv[4] = '{32'h0000_0110, 32'h1000_FFFF, 32'd5};
        lv[5] = '{32'h0000_0114, 32'h0000_0000, 32'd6};
        pv[0] = '{1, 32'h0000_0044, 2'b10};
        pv[1] = '{1, 32'h0000_0048, 2'b10};
        pv[2] = '{0, 32'hFFFF_FFFC, 2'b01};

        reset_in = 1'b1; start_in = 1'b0; halt_in = 1'b0;
        bus.load_valid_in = 1'b0; bus.load_address_in = '0; bus.load_instr_in = '0;
        bus.probe_req_in = '0; bus.probe_address_in = '0;
        #2 reset_in = 1'b0;
        #1;
        check("rst_cpu_reset", cpu_reset_out, 1);
        check("rst_write", bus.instrWrite_out, 0);
        check("rst_count", load_count_out, 0);
        check("rst_ack", bus.probe_ack_out, 0);
        check("rst_pdata", bus.probe_data_out, 0);
        check("rst_ready", bus.load_ready_out, 1);
        tick(); tick();
        reset_in = 1'b1;
        tick();

        // Simultaneous probes: channel 0 first, channel 1 one cycle later.
        bus.probe_req_in = 2'b11;
        bus.probe_address_in[0] = 32'h10;
        bus.probe_address_in[1] = 32'h14;
        #1 check("rr_first_addr", bus.read_data_address_out, 32'h10);
        tick();
        check("rr_ack0", bus.probe_ack_out, 2'b01);
        check("rr_data0", bus.probe_data_out[0], mem_model(32'h10));
        check("rr_second_addr", bus.read_data_address_out, 32'h14);
        bus.probe_req_in = 2'b10;
        tick();
        check("rr_ack1", bus.probe_ack_out, 2'b10);
        check("rr_data1", bus.probe_data_out[1], mem_model(32'h14));
        check("rr_no_regrant", bus.read_data_address_out, 0);
        bus.probe_req_in = 2'b00;
        tick();
        check("rr_ack_idle", bus.probe_ack_out, 0);

        for (int i = 0; i < 3; i++) begin
            bus.probe_req_in = 2'b00;
            bus.probe_req_in[pv[i].ch] = 1'b1;
            bus.probe_address_in[pv[i].ch] = pv[i].addr;
            #1 check($sformatf("probe%0d_addr", i), bus.read_data_address_out, pv[i].addr);
            tick();
            check($sformatf("probe%0d_ack", i), bus.probe_ack_out, pv[i].exp_ack);
            check($sformatf("probe%0d_data", i), bus.probe_data_out[pv[i].ch], mem_model(pv[i].addr));
            bus.probe_req_in = 2'b00;
            tick();
        end
        // Last grant was channel 0, so channel 1 wins a tie now.
        bus.probe_req_in = 2'b11;
        #1 check("rr_rotate", bus.read_data_address_out, bus.probe_address_in[1]);
        tick();
        bus.probe_req_in = 2'b01;
        tick();
        bus.probe_req_in = 2'b00;
        tick();

        // Three words then start.
        wr_q.delete();
        bus.load_valid_in = 1'b1; bus.load_address_in = 32'h0; bus.load_instr_in = 32'h2008_0005;
        tick();
        check("lat_no_strobe_yet", bus.instrWrite_out, 0);
        bus.load_address_in = 32'h4; bus.load_instr_in = 32'h2009_0003;
        tick();
        check("lat_strobe", bus.instrWrite_out, 1);
        check("lat_addr", bus.instr_address_out, 32'h0);
        check("lat_data", bus.instr_out, 32'h2008_0005);
        check("lat_count", load_count_out, 1);
        bus.load_address_in = 32'h8; bus.load_instr_in = 32'h0109_5020;
        tick();
        bus.load_valid_in = 1'b0; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        check("s1_drain_held", cpu_reset_out, 1);
        tick(); tick();
        check("s1_run", cpu_reset_out, 0);
        check("s1_ready_run", bus.load_ready_out, 0);
        check("s1_count", load_count_out, 3);
        check("s1_nwrites", wr_q.size(), 3);
        if (wr_q.size() == 3) begin
            check("s1_w0", {wr_q[0].addr, wr_q[0].data}, {32'h0, 32'h2008_0005});
            check("s1_w1", {wr_q[1].addr, wr_q[1].data}, {32'h4, 32'h2009_0003});
            check("s1_w2", {wr_q[2].addr, wr_q[2].data}, {32'h8, 32'h0109_5020});
        end
        halt_in = 1'b1;
        tick();
        halt_in = 1'b0;
        check("halt_cpu_reset", cpu_reset_out, 1);
        check("halt_count", load_count_out, 0);
        start_in = 1'b1; halt_in = 1'b1;
        tick();
        start_in = 1'b0; halt_in = 1'b0;
        check("halt_over_start", cpu_reset_out, 1);

        // Six back-to-back words.
        wr_q.delete();
        for (int i = 0; i < 6; i++) begin
            bus.load_valid_in = 1'b1;
            bus.load_address_in = lv[i].addr;
            bus.load_instr_in = lv[i].instr;
            #1 check($sformatf("b2b_ready%0d", i), bus.load_ready_out, 1);
            tick();
        end
        bus.load_valid_in = 1'b0;
        tick(); tick(); tick();
        check("b2b_nwrites", wr_q.size(), 6);
        for (int i = 0; i < 6 && i < wr_q.size(); i++)
            check($sformatf("b2b_w%0d", i), {wr_q[i].addr, wr_q[i].data, wr_q[i].count},
                  {lv[i].addr, lv[i].instr, lv[i].exp_count});
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        check("b2b_run", cpu_reset_out, 0);
        halt_in = 1'b1;
        tick();
        halt_in = 1'b0;

        // Start on the edge the second word is accepted: DRAIN then RUN.
        bus.load_valid_in = 1'b1; bus.load_address_in = 32'h200; bus.load_instr_in = 32'h1111_1111;
        tick();
        bus.load_address_in = 32'h204; bus.load_instr_in = 32'h2222_2222; start_in = 1'b1;
        tick();
        bus.load_valid_in = 1'b0; start_in = 1'b0;
        check("dr_w0", {bus.instrWrite_out, bus.instr_address_out}, {1'b1, 32'h200});
        check("dr_held0", cpu_reset_out, 1);
        tick();
        check("dr_w1", {bus.instrWrite_out, bus.instr_address_out}, {1'b1, 32'h204});
        check("dr_held1", cpu_reset_out, 1);
        tick();
        check("dr_idle", {bus.instrWrite_out, cpu_reset_out}, {1'b0, 1'b1});
        tick();
        check("dr_run", cpu_reset_out, 0);
        check("dr_count", load_count_out, 2);
        halt_in = 1'b1;
        tick();
        halt_in = 1'b0;
        check("dr_halt", {cpu_reset_out, load_count_out}, {1'b1, 32'h0});

`ifdef MIPS_LOADER_CHECKSUM_EN
        check("cs_cleared", checksum_out, 0);
        bus.load_valid_in = 1'b1; bus.load_address_in = 32'h0; bus.load_instr_in = 32'h0000_FFFF;
        tick();
        bus.load_address_in = 32'h4; bus.load_instr_in = 32'h00FF_00FF;
        tick();
        bus.load_valid_in = 1'b0;
        tick(); tick();
        check("cs_value", checksum_out, 32'h00FF_FF00);
`endif

        // Reset in the middle of a stream discards pending words.
        for (int i = 0; i < 3; i++) begin
            bus.load_valid_in = 1'b1;
            bus.load_address_in = 32'h300 + 32'(4 * i);
            bus.load_instr_in = 32'hC0DE_0000 + 32'(i);
            tick();
        end
        n0 = wr_q.size();
        reset_in = 1'b0; bus.load_valid_in = 1'b0;
        #1;
        check("ar_write", bus.instrWrite_out, 0);
        check("ar_addr_data", {bus.instr_address_out, bus.instr_out}, 0);
        check("ar_cpu_reset", cpu_reset_out, 1);
        check("ar_count", load_count_out, 0);
        check("ar_pdata", bus.probe_data_out, 0);
        check("ar_ack", bus.probe_ack_out, 0);
`ifdef MIPS_LOADER_CHECKSUM_EN
        check("ar_checksum", checksum_out, 0);
`endif
        tick(); tick();
        reset_in = 1'b1;
        tick(); tick(); tick(); tick();
        check("ar_no_strobe", wr_q.size(), n0);
        check("ar_count_after", load_count_out, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_loader.md
MIPS_LOADER -- requirements
Module: mips_loader

Interface
REQ-001 Parameter WIDTH, default 32: address/instruction/data word width.
REQ-002 Parameter DEPTH, default 4: load FIFO entries, power of two, at least 2.
REQ-003 Parameter CHANNELS, default 2: number of data-memory probe channels, at least 1.
REQ-004 Ports SHALL be:
- clock  in  1  single clock, rising edge.
- reset_in  in  1  asynchronous, active-low reset.
- load_valid_in  in  1  host offers a load word.
- load_ready_out  out  1  loader accepts the word.
- load_address_in  in  WIDTH  instruction address.
- load_instr_in  in  WIDTH  instruction word.
- start_in  in  1  release the core once loading completes.
- halt_in  in  1  return the core to hold.
- cpu_reset_out  out  1  1 = core held in reset.
- instrWrite_out  out  1  instruction-memory write strobe.
- instr_address_out  out  WIDTH  write address.
- instr_out  out  WIDTH  write data.
- load_count_out  out  WIDTH  words written since the last HOLD entry.
- probe_req_in  in  CHANNELS  per-channel read request.
- probe_address_in  in  CHANNELS x WIDTH  per-channel data address.
- probe_ack_out  out  CHANNELS  per-channel one-cycle completion pulse.
- probe_data_out  out  CHANNELS x WIDTH  per-channel read result.
- read_data_address_out  out  WIDTH  data-memory read address.
- read_data_in  in  WIDTH  data-memory combinational read data.

Function
REQ-005 A load word SHALL be accepted at a rising edge when load_valid_in and load_ready_out are both 1.
REQ-006 load_ready_out SHALL be combinational: 1 when the FIFO is not full and the state is not RUN.
REQ-007 When the FIFO is non-empty at an edge, the loader SHALL pop the head entry and drive instrWrite_out=1 with that entry's address and data for exactly the following cycle.
REQ-008 Minimum latency from acceptance to the write strobe SHALL be 1 cycle.
REQ-009 Push and pop in the same edge SHALL both take effect. FIFO pointers SHALL wrap modulo DEPTH. Order SHALL be strict FIFO.
REQ-010 The FSM SHALL have four states, with these transitions:
- HOLD -> LOAD on the first accepted word.
- HOLD -> RUN on start_in with the FIFO empty.
- LOAD -> DRAIN on start_in with the FIFO non-empty.
- LOAD -> RUN on start_in with the FIFO empty.
- DRAIN -> RUN when the FIFO becomes empty and no write is pending.
- RUN -> HOLD on halt_in.
REQ-011 halt_in SHALL have priority over start_in when both are asserted.
REQ-012 cpu_reset_out SHALL be a registered 0 only in RUN, and 1 in every other state.
REQ-013 load_count_out SHALL increment on each instrWrite_out cycle, wrap at 2^WIDTH, and clear on the RUN->HOLD transition.
REQ-014 Probe arbitration SHALL be round-robin, one grant per cycle; the search starts at the index after the last grant.
REQ-015 read_data_address_out SHALL combinationally equal probe_address_in of the granted channel, and 0 when no channel is granted.
REQ-016 At the grant edge, read_data_in SHALL be latched into probe_data_out of the granted channel, and probe_ack_out of that channel SHALL pulse in the next cycle.
REQ-017 A requester SHALL hold probe_req_in and probe_address_in until its ack. A channel SHALL NOT be re-granted in its ack cycle.
REQ-018 Probes SHALL operate in all FSM states, independently of loading.

Reset
REQ-019 Reset asserted (reset_in=0) SHALL immediately, asynchronously, apply all of the following:
- state = HOLD
- FIFO empty
- cpu_reset_out = 1
- instrWrite_out, instr_address_out, instr_out = 0
- load_count_out = 0
- probe_ack_out, probe_data_out = 0
- round-robin pointer = channel 0
REQ-020 Reset asserted mid-drain SHALL discard all queued words; no write strobe SHALL follow the reset release.

Configuration
REQ-021 Macro MIPS_LOADER_CHECKSUM_EN, when defined, SHALL add an output checksum_out (WIDTH bits).
- Value: XOR of every instr_out written, cleared with load_count_out and at reset.
- When the macro is undefined, the port and its logic SHALL be absent.

Structure
REQ-022 A shared package SHALL hold the WIDTH default and the state enum loader_state_t {HOLD, LOAD, DRAIN, RUN}.
REQ-023 The FIFO SHALL be a separate sub-module, loader_fifo, parametrised by WIDTH and DEPTH, with push/pop/full/empty.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Reset, then 3 words (addr 0/4/8, data 0x20080005/0x20090003/0x01095020) and start_in -> three single-cycle strobes in order, load_count_out=3, then RUN and cpu_reset_out=0.
- DEPTH=4, 6 back-to-back words with one pop per cycle -> load_ready_out never blocks a push while not full, all 6 written in order, no loss.
- Channel 0 and channel 1 request simultaneously (addr 0x10/0x14) -> grant 0 acked first, channel 1 acked one cycle later, each probe_data_out matching memory.
- start_in while 2 words are queued -> DRAIN, both writes complete, then RUN; halt_in in RUN -> HOLD, cpu_reset_out=1, load_count_out=0.
- reset_in=0 with 3 words queued -> no further strobes, all outputs at reset values.
- With MIPS_LOADER_CHECKSUM_EN: after writing 0x0000FFFF and 0x00FF00FF -> checksum_out=0x00FFFF00.
